// File: rtl/pc_target_pkg.sv
// Shared widths and state type for the PC target encoder.
// Also imported by the forward lookup and the loader.
package pc_target_pkg;

  localparam int D = 12;
  localparam int A = 6;
  localparam int N = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } encoder_state_t;

endpackage

// File: rtl/target_table.sv
// N x (D+1) target register file: one write port, bulk clear,
// one combinational read port. Ports: wr_*, clr, rd_addr -> rd_valid/rd_data.
module target_table
  import pc_target_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         clr,
  input  logic [A-1:0] rd_addr,
  output logic         rd_valid,
  output logic [D-1:0] rd_data
);

  logic [D-1:0] data [N];
  logic [N-1:0] vld;

  always_ff @(posedge clk) begin
    if (wr_en) data[wr_addr] <= wr_data;
  end

  // The write lands after the clear, so a coinciding write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (clr) vld <= '0;
      if (wr_en) vld[wr_addr] <= 1'b1;
    end
  end

  assign rd_valid = vld[rd_addr];
  assign rd_data  = data[rd_addr];

endmodule

// File: rtl/pc_target_encoder.sv
// Reverse target lookup: sequential search of the target table for req_target,
// returning hit flag and lowest matching index over valid/ready handshakes.
module pc_target_encoder
  import pc_target_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         clr,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [D-1:0] req_target,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_hit,
  output logic [A-1:0] rsp_addr,
  output logic         busy
);

  localparam logic [A-1:0] LAST = A'(N - 1);

  encoder_state_t state;
  logic [A-1:0]   idx;
  logic [D-1:0]   key;
  logic           rd_valid;
  logic [D-1:0]   rd_data;
  logic           match;

  target_table u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr      (clr),
    .rd_addr  (idx),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign match = rd_valid && (rd_data == key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      key      <= '0;
      rsp_hit  <= 1'b0;
      rsp_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            key   <= req_target;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            rsp_hit  <= 1'b1;
            rsp_addr <= idx;
            state    <= RESP;
          end else if (idx == LAST) begin
            rsp_hit  <= 1'b0;
            rsp_addr <= '0;
            state    <= RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: doc/pc_target_encoder.md
Name: pc_target_encoder

Overview:
- Reverse of the branch-target lookup: takes a 12-bit absolute PC target and returns the 6-bit table index that encodes it.
- Used by the program loader and self-check logic to produce branch-immediate fields from resolved targets.
- Holds a writable 64-entry target table and searches it sequentially, one entry per cycle.
- Uses valid/ready handshakes on the request and response sides.

Parameters:
- D, 12, PC / target width in bits
- A, 6, index width in bits
- N, 64, table depth (must equal 2**A)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  A  table index to write
- wr_data  in  D  target value to store
- clr  in  1  synchronous invalidate of all entries
- req_valid  in  1  search request valid
- req_ready  out  1  encoder can accept a request
- req_target  in  D  target to search for
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_hit  out  1  1 = target found
- rsp_addr  out  A  lowest matching index (0 on miss)
- busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to IDLE; all entry valid bits clear; table data is don't-care.
  - rsp_valid=0, rsp_hit=0, rsp_addr=0, busy=0, req_ready=1 once rst_n is released.
- Table:
  - Each entry holds D data bits plus a valid bit.
  - On wr_en at an edge, table[wr_addr] takes wr_data and its valid bit sets. Writes are accepted in every state.
  - On clr at an edge, all valid bits clear. If clr and wr_en coincide, clr wins for all entries except wr_addr, which ends up valid with wr_data.
- States are IDLE, SCAN and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch req_target into key, set idx=0, go to SCAN.
- SCAN:
  - req_ready=0.
  - Each cycle, compare key with table[idx] using current register contents. A write to idx on the same edge is not seen.
  - Match (valid and data==key): set rsp_hit=1, rsp_addr=idx, go to RESP.
  - No match and idx==N-1: set rsp_hit=0, rsp_addr=0, go to RESP.
  - Otherwise idx increments.
  - Lowest matching index always wins. Entries written behind idx during a scan are not revisited.
- RESP:
  - rsp_valid=1; rsp_hit and rsp_addr are held stable until rsp_valid&&rsp_ready at an edge, then go to IDLE.
  - req_ready stays 0 in RESP, so there is no request overlap. A new request is accepted at the earliest one cycle after the response handshake.
- Latency, counting from the request acceptance edge:
  - Hit at index k: rsp_valid rises after k+1 further edges.
  - Miss: rsp_valid rises after N edges.
  - Best case is 1 edge; worst case is 64 edges.
- rsp_addr and rsp_hit are registered outputs. rsp_valid and req_ready decode from the registered state only, with no combinational path from any input.
- Index 0 holds the halt / done-flag target 4095 by loader convention. The block gives index 0 no special treatment.
- req_target is sampled only at acceptance; later changes are ignored.
- A reset mid-scan or mid-response aborts immediately. No response is produced and the table is invalidated.

Decomposition:
- Package pc_target_pkg holds D, A, N and the state enum encoder_state_t {IDLE, SCAN, RESP}. The forward lookup and loader also import D and A from it.
- One sub-module, target_table: N x (D+1) register file with one write port, clr, and one combinational read port indexed by idx.
- The FSM, idx counter and output registers stay in pc_target_encoder.

Test Plan:
- Basic hit: write idx2=34 and idx3=50, then request 50 → rsp_valid after 4 edges, rsp_hit=1, rsp_addr=3.
- Duplicates: write idx5=127 and idx9=127, then request 127 → rsp_addr=5, latency 6 edges.
- Miss and worst case: after reset, write idx0=4095, then request 999 → rsp_hit=0, rsp_addr=0, rsp_valid after exactly 64 edges. Next, clr and request 4095 → miss.
- Backpressure: hit on idx1=1 with rsp_ready held 0 for 3 cycles → rsp_valid, rsp_hit and rsp_addr stable, req_ready=0 throughout. Raise rsp_ready → IDLE next edge, req_ready=1.
- Write during scan: request 200 with an empty table; write idx1=200 while idx=10 → miss. Repeat with the write at idx=0 → hit, rsp_addr=1.
- Async reset mid-scan: assert rst_n=0 at idx=20 between edges → busy=0 and rsp_valid=0 immediately. A re-request for a previously written value → miss.
